ps2_rx: RTL and testbench

PS2_RX -- requirements
Module: ps2_rx

---
 rtl/ps2_rx.sv | 162 ++++++++++++++++
 tb/tb_ps2_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the PS/2 lines and deframes 11-bit frames into scancode bytes.
// Build option: define PS2_PARITY_CHECK_EN to reject frames whose odd-parity bit does not match the data.
module ps2_rx #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 12500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       strobe_out,
   output logic [7:0] code_out,
   output logic       frame_err,
   output logic       busy
);

   localparam int FW   = $clog2(FILTER_LEN + 1);
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   logic            r_clk_p0;
   logic            r_clk_p1;
   logic            r_dat_p0;
   logic            r_dat_p1;
   logic            r_filt_clk;
   logic [FW-1:0]   r_filt_cnt;
   logic            r_fall;
   state_t          r_state;
   logic [2:0]      r_bit_cnt;
   logic [7:0]      r_shift;
   logic            r_parity;
   logic [TO_W-1:0] r_to_cnt;
   logic [7:0]      r_code;
   logic            r_strobe;
   logic            r_err;
   logic            r_busy;
   logic            w_par_ok;
   logic            w_timeout;

   // Stage p0/p1: two-flop synchronizers for both asynchronous PS/2 lines
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_p0 <= 1'b1;
         r_clk_p1 <= 1'b1;
         r_dat_p0 <= 1'b1;
         r_dat_p1 <= 1'b1;
      end else begin
         r_clk_p0 <= ps2_clk;
         r_clk_p1 <= r_clk_p0;
         r_dat_p0 <= ps2_data;
         r_dat_p1 <= r_dat_p0;
      end
   end

   // Filter stage: the clock flips only on the FILTER_LEN-th consecutive differing sample
   always_ff @(posedge clk) begin
      if (reset) begin
         r_filt_clk <= 1'b1;
         r_filt_cnt <= '0;
         r_fall     <= 1'b0;
      end else begin
         r_fall <= 1'b0;
         if (r_clk_p1 == r_filt_clk) begin
            r_filt_cnt <= '0;
         end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
            r_filt_clk <= r_clk_p1;
            r_filt_cnt <= '0;
            r_fall     <= r_filt_clk;
         end else begin
            r_filt_cnt <= r_filt_cnt + FW'(1);
         end
      end
   end

   // The parity bit is always captured; it only gates acceptance when checking is built in.
   assign w_par_ok  = ~PAR_EN | (^{r_shift, r_parity});
   assign w_timeout = (r_state != ST_IDLE) && !r_fall &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Deframer stage: sampled data is taken in the same cycle the filtered falling edge is flagged
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_to_cnt  <= '0;
         r_code    <= '0;
         r_strobe  <= 1'b0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_strobe <= 1'b0;
         r_err    <= 1'b0;
         if ((r_state == ST_IDLE) || r_fall) begin
            r_to_cnt <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end

         if (w_timeout) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_err    <= 1'b1;
            r_to_cnt <= '0;
         end else if (r_fall) begin
            case (r_state)
               ST_IDLE: begin
                  if (!r_dat_p1) begin
                     r_state   <= ST_DATA;
                     r_busy    <= 1'b1;
                     r_bit_cnt <= '0;
                  end
               end
               ST_DATA: begin
                  r_shift   <= {r_dat_p1, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  r_parity <= r_dat_p1;
                  r_state  <= ST_STOP;
               end
               ST_STOP: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  if (r_dat_p1 && w_par_ok) begin
                     r_code   <= r_shift;
                     r_strobe <= 1'b1;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign strobe_out = r_strobe;
   assign code_out   = r_code;
   assign frame_err  = r_err;
   assign busy       = r_busy;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed PS/2 frames against a frame-level outcome model and a per-cycle compare process.
module tb_ps2_rx;

   localparam int FILTER_LEN     = 4;
   localparam int TIMEOUT_CYCLES = 12500;
   localparam int HALF           = 20;

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_CHECK = 1'b1;
`else
   localparam bit PAR_CHECK = 1'b0;
`endif

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       ps2_clk  = 1'b1;
   logic       ps2_data = 1'b1;
   logic       strobe_out;
   logic [7:0] code_out;
   logic       frame_err;
   logic       busy;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [8:0] exp_q[$];
   logic [7:0] exp_code = 8'h00;
   logic [8:0] e;
   logic [8:0] mo;

   ps2_rx #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .strobe_out(strobe_out),
      .code_out  (code_out),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Odd parity bit: set when the data byte has an even number of ones.
   function automatic logic odd_par(input logic [7:0] d);
      return ($countones(d) % 2) == 0;
   endfunction

   // Frame outcome: bit 8 set = frame_err, otherwise strobe with the byte in bits 7:0.
   function automatic logic [8:0] model_outcome(input logic [7:0] d, input logic p, input logic s);
      int ones;
      ones = $countones(d) + int'(p);
      if (!s) return 9'h100;
      if (PAR_CHECK && (ones % 2 == 0)) return 9'h100;
      return {1'b0, d};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      ps2_data = b;
      if (glitch) begin
         cyc(8); ps2_clk = 1'b0; cyc(FILTER_LEN - 1); ps2_clk = 1'b1; cyc(HALF - 8 - (FILTER_LEN - 1));
      end else begin
         cyc(HALF);
      end
      ps2_clk = 1'b0;
      if (glitch) begin
         cyc(8); ps2_clk = 1'b1; cyc(FILTER_LEN - 1); ps2_clk = 1'b0; cyc(HALF - 8 - (FILTER_LEN - 1));
      end else begin
         cyc(HALF);
      end
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit glitch);
      exp_q.push_back(model_outcome(d, p, s));
      send_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
      send_bit(p, glitch);
      send_bit(s, glitch);
   endtask

   task automatic send_partial(input logic [7:0] d, input int nbits);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) send_bit(d[i], 1'b0);
   endtask

   task automatic drain(input string name);
      ps2_data = 1'b1;
      cyc(40);
      @(negedge clk);
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   // Compare process: every pulse must match the next modelled outcome, and code_out must hold otherwise.
   always @(negedge clk) begin
      if (reset) begin
         exp_code = 8'h00;
      end else begin
         if (strobe_out || frame_err) begin
            check("no_overlap", 32'(strobe_out & frame_err), 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", 32'({strobe_out, frame_err}), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("pulse_kind", 32'({frame_err, strobe_out}), 32'(e[8] ? 2'b10 : 2'b01));
               if (!e[8]) exp_code = e[7:0];
            end
         end
         check("code_out", 32'(code_out), 32'(exp_code));
      end
   end

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(3);
      @(negedge clk);
      check("rst_code", 32'(code_out), 32'h00);
      check("rst_strobe", 32'(strobe_out), 32'd0);
      check("rst_err", 32'(frame_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      check("par_1C", 32'(odd_par(8'h1C)), 32'd0);
      check("par_F0", 32'(odd_par(8'hF0)), 32'd1);
      check("par_32", 32'(odd_par(8'h32)), 32'd0);
      check("par_5A", 32'(odd_par(8'h5A)), 32'd1);
      mo = model_outcome(8'h32, 1'b1, 1'b1);
      check("model_badpar", 32'(mo), PAR_CHECK ? 32'h100 : 32'h032);
      mo = model_outcome(8'h45, 1'b0, 1'b0);
      check("model_stop0", 32'(mo), 32'h100);
      reset = 1'b0;
      cyc(5);

      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      drain("drain_1C");
      check("code_1C", 32'(code_out), 32'h1C);
      check("busy_after_1C", 32'(busy), 32'd0);

      send_bit(1'b1, 1'b0);
      drain("drain_idle_one");
      check("busy_idle_one", 32'(busy), 32'd0);

      send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      drain("drain_b2b");
      check("code_b2b", 32'(code_out), 32'h1C);

      send_frame(8'h32, ~odd_par(8'h32), 1'b1, 1'b0);
      drain("drain_badpar");
      send_frame(8'h32, odd_par(8'h32), 1'b1, 1'b0);
      drain("drain_goodpar");
      check("code_32", 32'(code_out), 32'h32);

      send_frame(8'h45, odd_par(8'h45), 1'b0, 1'b0);
      drain("drain_stop0");
      check("code_after_stop0", 32'(code_out), 32'h32);

      send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b1);
      drain("drain_glitch");
      check("code_5A", 32'(code_out), 32'h5A);

      send_partial(8'h23, 3);
      @(negedge clk);
      check("busy_partial", 32'(busy), 32'd1);
      exp_q.push_back(9'h100);
      cyc(TIMEOUT_CYCLES - 100);
      @(negedge clk);
      check("busy_before_timeout", 32'(busy), 32'd1);
      check("no_early_timeout", 32'(exp_q.size()), 32'd1);
      cyc(110);
      cyc(20);
      @(negedge clk);
      check("busy_after_timeout", 32'(busy), 32'd0);
      drain("drain_timeout");
      send_frame(8'h23, odd_par(8'h23), 1'b1, 1'b0);
      drain("drain_23");
      check("code_23", 32'(code_out), 32'h23);

      send_partial(8'h21, 5);
      ps2_data = 1'b1;
      @(negedge clk);
      check("busy_mid_21", 32'(busy), 32'd1);
      cyc(0);
      reset = 1'b1;
      cyc(3);
      reset = 1'b0;
      @(negedge clk);
      check("busy_after_reset", 32'(busy), 32'd0);
      check("code_after_reset", 32'(code_out), 32'h00);
      cyc(5);
      send_frame(8'h21, odd_par(8'h21), 1'b1, 1'b0);
      drain("drain_21");
      check("code_21", 32'(code_out), 32'h21);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
